// File: rtl/optical_flow_pkg.sv
`default_nettype none
// ============================================================================
// optical_flow_pkg : frame constants and state encoding shared by the flow
//                    pipeline (warper, residual stage, flow estimator)
// Revision: 1.0
// ============================================================================
package optical_flow_pkg;

  localparam int PIXEL_WIDTH  = 8;
  localparam int WIDTH        = 160;
  localparam int HEIGHT       = 120;
  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_WIDTH   = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } residual_state_e;

endpackage
`default_nettype wire

// File: rtl/warp_residual_abs_diff.sv
`default_nettype none
// ============================================================================
// abs_diff : combinational absolute difference of two pixels plus a strict
//            "difference above threshold" flag
// Revision: 1.0
// ============================================================================
module abs_diff #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] i_a,
  input  logic [PIXEL_WIDTH-1:0] i_b,
  input  logic [PIXEL_WIDTH-1:0] i_thresh,
  output logic [PIXEL_WIDTH-1:0] o_diff,
  output logic                   o_over
);

  localparam logic [PIXEL_WIDTH-1:0] c_one = PIXEL_WIDTH'(1);

  logic [PIXEL_WIDTH:0] w_sub;

  // The extra MSB is the borrow; when set, negating the low bits gives b-a.
  assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff = w_sub[PIXEL_WIDTH] ? (~w_sub[PIXEL_WIDTH-1:0] + c_one)
                                     : w_sub[PIXEL_WIDTH-1:0];
  assign o_over = (o_diff > i_thresh);

endmodule
`default_nettype wire

// File: rtl/warp_residual.sv
`default_nettype none
// ============================================================================
// warp_residual : streams warped and reference frames, writes |warped-ref|
//                 to the residual BRAM and accumulates SAD / outlier count
// Revision: 1.0
// ============================================================================
module warp_residual #(
  parameter int PIXEL_WIDTH = optical_flow_pkg::PIXEL_WIDTH,
  parameter int WIDTH       = optical_flow_pkg::WIDTH,
  parameter int HEIGHT      = optical_flow_pkg::HEIGHT,
  parameter int ADDR_WIDTH  = optical_flow_pkg::ADDR_WIDTH,
  parameter int SUM_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PIXEL_WIDTH-1:0] thresh,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_re,
  input  logic [PIXEL_WIDTH-1:0] warped_pixel_data,
  input  logic [PIXEL_WIDTH-1:0] ref_pixel_data,
  output logic [ADDR_WIDTH-1:0]  res_addr,
  output logic [PIXEL_WIDTH-1:0] res_data,
  output logic                   res_we,
  output logic [SUM_WIDTH-1:0]   sad_sum,
  output logic [ADDR_WIDTH-1:0]  outlier_count
);

  import optical_flow_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

  residual_state_e r_state;
  residual_state_e w_next;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_drain;
  logic [PIXEL_WIDTH-1:0] r_thresh;
  logic                   r_rd_re;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic                   r_v1;
  logic [ADDR_WIDTH-1:0]  r_a1;
  logic                   r_res_we;
  logic [ADDR_WIDTH-1:0]  r_res_addr;
  logic [PIXEL_WIDTH-1:0] r_res_data;
  logic [SUM_WIDTH-1:0]   r_sad_sum;
  logic [ADDR_WIDTH-1:0]  r_outlier_count;

  logic [PIXEL_WIDTH-1:0] w_diff;
  logic                   w_over;

  abs_diff #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_abs_diff (
    .i_a      (warped_pixel_data),
    .i_b      (ref_pixel_data),
    .i_thresh (r_thresh),
    .o_diff   (w_diff),
    .o_over   (w_over)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (r_rd_addr == c_last_addr) w_next = ST_DRAIN;
      ST_DRAIN: if (r_drain) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_drain         <= 1'b0;
      r_thresh        <= '0;
      r_rd_re         <= 1'b0;
      r_rd_addr       <= '0;
      r_v1            <= 1'b0;
      r_a1            <= '0;
      r_res_we        <= 1'b0;
      r_res_addr      <= '0;
      r_res_data      <= '0;
      r_sad_sum       <= '0;
      r_outlier_count <= '0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != ST_IDLE);
      r_done   <= (w_next == ST_DONE);
      r_drain  <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
      // Read-latency stage: data for r_a1 is on the BRAM outputs this cycle.
      r_v1     <= r_rd_re;
      r_a1     <= r_rd_addr;
      r_res_we <= r_v1;

      if ((r_state == ST_IDLE) && start) begin
        r_thresh        <= thresh;
        r_rd_re         <= 1'b1;
        r_rd_addr       <= '0;
        r_sad_sum       <= '0;
        r_outlier_count <= '0;
      end else begin
        if (r_state == ST_RUN) begin
          if (r_rd_addr == c_last_addr) begin
            r_rd_re   <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        if (r_v1) begin
          r_res_addr      <= r_a1;
          r_res_data      <= w_diff;
          r_sad_sum       <= r_sad_sum + SUM_WIDTH'(w_diff);
          r_outlier_count <= r_outlier_count + ADDR_WIDTH'(w_over);
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign rd_addr       = r_rd_addr;
  assign rd_re         = r_rd_re;
  assign res_addr      = r_res_addr;
  assign res_data      = r_res_data;
  assign res_we        = r_res_we;
  assign sad_sum       = r_sad_sum;
  assign outlier_count = r_outlier_count;

endmodule
`default_nettype wire

// File: tb/tb_warp_residual.sv
`default_nettype none
// ============================================================================
// tb_warp_residual : scoreboard bench for warp_residual with directed frames
// Revision: 1.0
// ============================================================================
module tb_warp_residual;

  localparam int PW = 8;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int N  = W * H;
  localparam int AW = 17;
  localparam int SW = 24;

  typedef struct {int addr; int data; int cyc;} wr_t;
  typedef struct {int sad; int outl; int cyc;} st_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] thresh = '0;
  logic          busy, done, rd_re, res_we;
  logic [AW-1:0] rd_addr, res_addr, outlier_count;
  logic [PW-1:0] warped_pixel_data, ref_pixel_data, res_data;
  logic [SW-1:0] sad_sum;

  logic [PW-1:0] warped_mem [0:N-1];
  logic [PW-1:0] ref_mem    [0:N-1];

  wr_t wq[$];
  st_t sq[$];
  wr_t mon_w;
  st_t mon_s;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  done_cnt = 0;
  bit  pass_done = 1'b0;

  warp_residual dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .thresh            (thresh),
    .busy              (busy),
    .done              (done),
    .rd_addr           (rd_addr),
    .rd_re             (rd_re),
    .warped_pixel_data (warped_pixel_data),
    .ref_pixel_data    (ref_pixel_data),
    .res_addr          (res_addr),
    .res_data          (res_data),
    .res_we            (res_we),
    .sad_sum           (sad_sum),
    .outlier_count     (outlier_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency BRAM models for the warped and reference frames.
  always @(posedge clk) begin
    if (rd_re) begin
      warped_pixel_data <= warped_mem[rd_addr];
      ref_pixel_data    <= ref_mem[rd_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (res_we) begin
      chk("write_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        mon_w = wq.pop_front();
        chk("res_addr", 64'(res_addr), 64'(mon_w.addr));
        chk("res_data", 64'(res_data), 64'(mon_w.data));
        chk("write_cycle", 64'(cyc), 64'(mon_w.cyc));
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_expected", 64'(sq.size() > 0), 64'd1);
      if (sq.size() > 0) begin
        mon_s = sq.pop_front();
        chk("sad_sum", 64'(sad_sum), 64'(mon_s.sad));
        chk("outlier_count", 64'(outlier_count), 64'(mon_s.outl));
        chk("done_cycle", 64'(cyc), 64'(mon_s.cyc));
        chk("busy_at_done", 64'(busy), 64'd1);
        pass_done = 1'b1;
      end
    end
  end

  // kind 0: identical ramps; 1: warped 200 / ref 50; 2: ramps equal except last pixel 0 vs 255
  task automatic load(input int kind);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        warped_mem[y*W+x] = (kind == 1) ? 8'd200 : 8'(x + y);
        ref_mem[y*W+x]    = (kind == 1) ? 8'd50  : 8'(x + y);
      end
    end
    if (kind == 2) begin
      warped_mem[N-1] = 8'd0;
      ref_mem[N-1]    = 8'd255;
    end
  endtask

  function automatic int exp_data(input int kind, input int k);
    if (kind == 1) return 150;
    if (kind == 2 && k == N - 1) return 255;
    return 0;
  endfunction

  task automatic run_pass(input int kind, input int thr, input int esad, input int eout,
                          input bit restart, input bit abort);
    int c0;
    load(kind);
    @(posedge clk);
    #1;
    c0 = cyc;
    wq.delete();
    sq.delete();
    for (int k = 0; k < N; k++) wq.push_back('{k, exp_data(kind, k), c0 + 3 + k});
    sq.push_back('{esad, eout, c0 + N + 3});
    pass_done = 1'b0;
    done_cnt  = 0;
    start  = 1'b1;
    thresh = PW'(thr);
    @(posedge clk);
    #1;
    start  = 1'b0;
    thresh = ~PW'(thr);
    chk("rd_re_cycle1", 64'(rd_re), 64'd1);
    chk("rd_addr_cycle1", 64'(rd_addr), 64'd0);
    chk("busy_cycle1", 64'(busy), 64'd1);
    if (abort) begin
      repeat (4999) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_res_we", 64'(res_we), 64'd0);
      chk("rst_sad", 64'(sad_sum), 64'd0);
      chk("rst_outliers", 64'(outlier_count), 64'd0);
      chk("rst_rd_re", 64'(rd_re), 64'd0);
      wq.delete();
      sq.delete();
      repeat (3) @(posedge clk);
      #1 chk("rst_no_writes", 64'(res_we), 64'd0);
      return;
    end
    if (restart) begin
      repeat (99) @(posedge clk);
      #1;
      start  = 1'b1;
      thresh = '0;
      @(posedge clk);
      #1;
      start  = 1'b0;
      thresh = ~PW'(thr);
    end
    for (int i = 0; i < N + 20 && !pass_done; i++) @(posedge clk);
    chk("done_seen", 64'(pass_done), 64'd1);
    for (int i = 0; i < 20 && cyc < c0 + N + 4; i++) @(posedge clk);
    #1;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_after_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("all_writes_seen", 64'(wq.size()), 64'd0);
    chk("held_sad", 64'(sad_sum), 64'(esad));
    chk("held_outliers", 64'(outlier_count), 64'(eout));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_re", 64'(rd_re), 64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    chk("reset_res_we", 64'(res_we), 64'd0);
    chk("reset_res_addr", 64'(res_addr), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    chk("reset_sad", 64'(sad_sum), 64'd0);
    chk("reset_outliers", 64'(outlier_count), 64'd0);
    rst = 1'b0;

    run_pass(1, 149, 0, 0, 1'b0, 1'b1);
    run_pass(0, 0, 0, 0, 1'b0, 1'b0);
    run_pass(1, 149, 2880000, 19200, 1'b0, 1'b0);
    run_pass(1, 150, 2880000, 0, 1'b1, 1'b0);
    run_pass(2, 0, 255, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
